// File: rtl/iter_div_if.sv
// Divide request/response bundle between the EX stage (master) and the divider (slave).
// start_i is held high until ready_o is seen; the result is consumed in the cycle start_i drops.
interface iter_div_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/iter_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle on magnitudes,
// sign fix-up on the way out. result_o = {remainder, quotient}.
module iter_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  iter_div_if.slave        div_if,
  output logic [1:0]       dbg_state_o
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
  logic               s1_q, s2_q, sgn_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;

  logic [WIDTH-1:0]   abs1_d, abs2_d, rem_d, quo_d, rem_fix_d, quo_fix_d;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   trial;
  logic               neg1, neg2;

  always_comb begin
    neg1   = div_if.signed_div_i & div_if.opdata1_i[WIDTH-1];
    neg2   = div_if.signed_div_i & div_if.opdata2_i[WIDTH-1];
    abs1_d = neg1 ? (~div_if.opdata1_i + ONE) : div_if.opdata1_i;
    abs2_d = neg2 ? (~div_if.opdata2_i + ONE) : div_if.opdata2_i;

    // Trial subtraction is one bit wider than the shifted remainder so its MSB is the borrow.
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, dvs_q};
    if (!trial[WIDTH+1]) begin
      rem_d = trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_d = shifted[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], 1'b0};
    end

    quo_fix_d = (sgn_q & (s1_q ^ s2_q)) ? (~quo_q + ONE) : quo_q;
    rem_fix_d = (sgn_q & s1_q) ? (~rem_q + ONE) : rem_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      sgn_q    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        FREE: begin
          ready_q  <= 1'b0;
          result_q <= '0;
          if (div_if.start_i && !div_if.annul_i) begin
            if (div_if.opdata2_i == '0) begin
              state_q <= BYZERO;
            end else begin
              state_q <= ON;
              quo_q   <= abs1_d;
              dvs_q   <= abs2_d;
              rem_q   <= '0;
              cnt_q   <= '0;
              s1_q    <= div_if.opdata1_i[WIDTH-1];
              s2_q    <= div_if.opdata2_i[WIDTH-1];
              sgn_q   <= div_if.signed_div_i;
            end
          end
        end
        BYZERO: begin
          if (div_if.annul_i) begin
            state_q <= FREE;
          end else begin
            state_q  <= END;
            result_q <= '0;
            ready_q  <= 1'b1;
          end
        end
        ON: begin
          if (div_if.annul_i) begin
            state_q <= FREE;
          end else if (cnt_q == CNT_LAST) begin
            state_q  <= END;
            result_q <= {rem_fix_d, quo_fix_d};
            ready_q  <= 1'b1;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        END: begin
          // Result is held until EX drops start_i; annul has no effect here.
          if (!div_if.start_i) begin
            state_q  <= FREE;
            ready_q  <= 1'b0;
            result_q <= '0;
          end
        end
        default: state_q <= FREE;
      endcase
    end
  end

  assign div_if.result_o = result_q;
  assign div_if.ready_o  = ready_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_iter_div_unit.sv
// Directed bench for iter_div_unit: latency, signed/unsigned results, divide-by-zero,
// annul, mid-divide reset, operand isolation and result hold in END.
module tb_iter_div_unit;
  logic clk;
  logic rst;
  logic [1:0] dbg_state;
  int checks;
  int failures;

  iter_div_if #(.WIDTH(32)) div_if ();

  iter_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .div_if      (div_if),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise start with the given operands and count edges (edge 0 included) until ready_o.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [63:0] res);
    div_if.signed_div_i = sgn;
    div_if.opdata1_i    = a;
    div_if.opdata2_i    = b;
    div_if.start_i      = 1'b1;
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (div_if.ready_o) break;
    end
    res = div_if.result_o;
  endtask

  task automatic drop_start();
    div_if.start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    div_if.signed_div_i = 1'b0;
    div_if.opdata1_i = '0;
    div_if.opdata2_i = '0;
    div_if.start_i = 1'b0;
    div_if.annul_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (div_if.ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", div_if.ready_o); end
    checks++; if (div_if.result_o !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", div_if.result_o); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_divu_basic();
    int lat; logic [63:0] res;
    run_div(1'b0, 32'd100, 32'd7, lat, res);
    checks++; if (lat !== 34) begin failures++; $display("FAIL divu_latency got=%0d exp=34", lat); end
    checks++; if (res !== {32'd2, 32'd14}) begin failures++; $display("FAIL divu_100_7 got=%h exp=%h", res, {32'd2, 32'd14}); end
    drop_start();
    checks++; if (div_if.ready_o !== 1'b0) begin failures++; $display("FAIL divu_drop_ready got=%0b exp=0", div_if.ready_o); end
    checks++; if (div_if.result_o !== 64'd0) begin failures++; $display("FAIL divu_drop_result got=%h exp=0", div_if.result_o); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL divu_drop_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_signed();
    logic        sgn_t [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] a_t   [5] = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] b_t   [5] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd2};
    logic [63:0] e_t   [5] = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD}, {32'h0000_0001, 32'hFFFF_FFFD},
                               {32'hFFFF_FFFF, 32'h0000_0003}, {32'h0000_0000, 32'h8000_0000},
                               {32'h0000_0001, 32'h7FFF_FFFC}};
    int lat; logic [63:0] res;
    for (int i = 0; i < 5; i++) begin
      run_div(sgn_t[i], a_t[i], b_t[i], lat, res);
      checks++; if (res !== e_t[i]) begin failures++; $display("FAIL signed_vec%0d got=%h exp=%h", i, res, e_t[i]); end
      drop_start();
    end
  endtask

  task automatic test_unsigned_edges();
    int lat; logic [63:0] res;
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, lat, res);
    checks++; if (res !== {32'd0, 32'hFFFF_FFFF}) begin failures++; $display("FAIL divu_max_by_1 got=%h exp=%h", res, {32'd0, 32'hFFFF_FFFF}); end
    drop_start();
    run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, res);
    checks++; if (res !== {32'h8000_0000, 32'd0}) begin failures++; $display("FAIL divu_small_by_big got=%h exp=%h", res, {32'h8000_0000, 32'd0}); end
    drop_start();
  endtask

  task automatic test_div_zero();
    int lat; logic [63:0] res;
    run_div(1'b1, 32'hDEAD_BEEF, 32'd0, lat, res);
    checks++; if (lat !== 2) begin failures++; $display("FAIL divzero_latency got=%0d exp=2", lat); end
    checks++; if (res !== 64'd0) begin failures++; $display("FAIL divzero_result got=%h exp=0", res); end
    drop_start();
    checks++; if (div_if.ready_o !== 1'b0) begin failures++; $display("FAIL divzero_drop_ready got=%0b exp=0", div_if.ready_o); end
    // Annul while in BYZERO returns to FREE without raising ready.
    div_if.opdata2_i = '0;
    div_if.start_i = 1'b1;
    @(posedge clk); #1;
    checks++; if (dbg_state !== 2'd1) begin failures++; $display("FAIL byzero_state got=%0d exp=1", dbg_state); end
    div_if.annul_i = 1'b1;
    div_if.start_i = 1'b0;
    @(posedge clk); #1;
    div_if.annul_i = 1'b0;
    checks++; if (dbg_state !== 2'd0 || div_if.ready_o !== 1'b0) begin failures++; $display("FAIL byzero_annul state=%0d ready=%0b exp=0/0", dbg_state, div_if.ready_o); end
  endtask

  task automatic test_annul();
    int lat; logic [63:0] res; bit saw_ready;
    div_if.signed_div_i = 1'b0;
    div_if.opdata1_i = 32'd1000;
    div_if.opdata2_i = 32'd3;
    div_if.start_i = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    div_if.annul_i = 1'b1;
    div_if.start_i = 1'b0;
    @(posedge clk); #1;
    div_if.annul_i = 1'b0;
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL annul_state got=%0d exp=0", dbg_state); end
    saw_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (div_if.ready_o) saw_ready = 1'b1;
    end
    checks++; if (saw_ready !== 1'b0) begin failures++; $display("FAIL annul_no_ready got=%0b exp=0", saw_ready); end
    run_div(1'b0, 32'd9, 32'd3, lat, res);
    checks++; if (lat !== 34 || res !== {32'd0, 32'd3}) begin failures++; $display("FAIL after_annul_9_3 lat=%0d res=%h exp=34/%h", lat, res, {32'd0, 32'd3}); end
    drop_start();
    // Start and annul together in FREE: annul wins.
    div_if.start_i = 1'b1;
    div_if.annul_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dbg_state !== 2'd0 || div_if.ready_o !== 1'b0) begin failures++; $display("FAIL start_annul_free state=%0d ready=%0b exp=0/0", dbg_state, div_if.ready_o); end
    div_if.start_i = 1'b0;
    div_if.annul_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid();
    div_if.signed_div_i = 1'b1;
    div_if.opdata1_i = 32'd12345;
    div_if.opdata2_i = 32'd17;
    div_if.start_i = 1'b1;
    repeat (21) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL rst_mid_state got=%0d exp=0", dbg_state); end
    checks++; if (div_if.ready_o !== 1'b0 || div_if.result_o !== 64'd0) begin failures++; $display("FAIL rst_mid_outputs ready=%0b result=%h exp=0/0", div_if.ready_o, div_if.result_o); end
    rst = 1'b0;
    div_if.start_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_operand_change();
    int lat;
    div_if.signed_div_i = 1'b0;
    div_if.opdata1_i = 32'd1000;
    div_if.opdata2_i = 32'd10;
    div_if.start_i = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    div_if.signed_div_i = 1'b1;
    div_if.opdata1_i = $urandom_range(32'hFFFF_FFFF, 32'h8000_0000);
    div_if.opdata2_i = $urandom_range(32'hFFFF, 32'h0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      lat++;
      if (div_if.ready_o) break;
    end
    checks++; if (lat !== 34 || div_if.result_o !== {32'd0, 32'd100}) begin failures++; $display("FAIL operand_change lat=%0d res=%h exp=34/%h", lat, div_if.result_o, {32'd0, 32'd100}); end
    drop_start();
  endtask

  task automatic test_end_hold();
    int lat; logic [63:0] res; bit bad;
    run_div(1'b0, 32'd50, 32'd6, lat, res);
    checks++; if (res !== {32'd2, 32'd8}) begin failures++; $display("FAIL end_50_6 got=%h exp=%h", res, {32'd2, 32'd8}); end
    div_if.annul_i = 1'b1;
    div_if.opdata1_i = 32'd7;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (div_if.ready_o !== 1'b1 || div_if.result_o !== {32'd2, 32'd8}) bad = 1'b1;
    end
    div_if.annul_i = 1'b0;
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL end_hold ready=%0b result=%h exp=1/%h", div_if.ready_o, div_if.result_o, {32'd2, 32'd8}); end
    drop_start();
    checks++; if (div_if.ready_o !== 1'b0) begin failures++; $display("FAIL end_release got=%0b exp=0", div_if.ready_o); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [63:0] res;
    run_div(1'b0, 32'd77, 32'd8, lat, res);
    checks++; if (res !== {32'd5, 32'd9}) begin failures++; $display("FAIL b2b_first got=%h exp=%h", res, {32'd5, 32'd9}); end
    drop_start();
    run_div(1'b1, 32'hFFFF_FF9C, 32'd9, lat, res);
    checks++; if (lat !== 34 || res !== {32'hFFFF_FFFF, 32'hFFFF_FFF5}) begin failures++; $display("FAIL b2b_second lat=%0d res=%h exp=34/%h", lat, res, {32'hFFFF_FFFF, 32'hFFFF_FFF5}); end
    drop_start();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_unsigned_edges();
    test_div_zero();
    test_annul();
    test_rst_mid();
    test_operand_change();
    test_end_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
